// File: rtl/comb_cut_sweeper.sv
// comb_cut_sweeper: exhaustive input sweeper for a combinational CUT.
// Applies vectors 0 .. 2^NUM_IN-1 in order, waits SETTLE_CYC cycles per
// vector, then folds the CUT outputs into a NUM_OUT-bit MISR signature.
module comb_cut_sweeper #(
   parameter int unsigned             NUM_IN     = 3,
   parameter int unsigned             NUM_OUT    = 15,
   parameter int unsigned             SETTLE_CYC = 2,
   parameter logic [NUM_OUT-1:0]      MISR_POLY  = NUM_OUT'(15'h6000),
   parameter logic [NUM_OUT-1:0]      MISR_SEED  = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   output logic [NUM_IN-1:0]  cut_x,
   input  logic [NUM_OUT-1:0] cut_f,
   output logic               busy,
   output logic               done,
   output logic [NUM_OUT-1:0] signature,
   output logic [NUM_IN-1:0]  vec_idx
);

   localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYC - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [NUM_OUT-1:0] misr_nxt;

   assign vec_idx = cut_x;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; abort overrides every transition while sweeping
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) state_nxt = SETTLE;
         end
         SETTLE: begin
            if (abort)          state_nxt = IDLE;
            else if (cnt == '0) state_nxt = CAPTURE;
         end
         CAPTURE: begin
            if (abort)           state_nxt = IDLE;
            else if (cut_x == '1) state_nxt = DONE;
            else                 state_nxt = SETTLE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from state: busy covers the sweep proper, done is the DONE cycle
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         SETTLE, CAPTURE: busy = 1'b1;
         DONE:            done = 1'b1;
         default: ;
      endcase
   end

   // MISR step: shift left, fold the outgoing msb through the tap mask, xor in the CUT outputs
   always_comb begin
      misr_nxt = {signature[NUM_OUT-2:0], 1'b0}
               ^ (signature[NUM_OUT-1] ? MISR_POLY : '0)
               ^ cut_f;
   end

   // Datapath: vector register, settle counter and signature
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cut_x     <= '0;
         cnt       <= '0;
         signature <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  cut_x     <= '0;
                  cnt       <= CNT_INIT;
                  signature <= MISR_SEED;
               end
            end
            SETTLE: begin
               if (abort) begin
                  cut_x <= '0;
               end else if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            CAPTURE: begin
               // an abort here leaves the partial signature untouched
               if (abort) begin
                  cut_x <= '0;
               end else begin
                  signature <= misr_nxt;
                  if (cut_x != '1) begin
                     cut_x <= cut_x + NUM_IN'(1);
                     cnt   <= CNT_INIT;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_comb_cut_sweeper.sv
// tb_comb_cut_sweeper: directed bench for comb_cut_sweeper with a signature scoreboard.
module tb_comb_cut_sweeper;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [1:0]  mode;
   logic [2:0]  cut_x;
   logic [2:0]  vec_idx;
   logic [14:0] cut_f;
   logic        busy;
   logic        done;
   logic [14:0] signature;

   logic        start_s;
   logic [1:0]  cut_x_s;
   logic [1:0]  vec_idx_s;
   logic [14:0] cut_f_s;
   logic        busy_s;
   logic        done_s;
   logic [14:0] signature_s;

   int total = 0;
   int bad   = 0;

   logic [14:0] exp_q[$];
   logic [14:0] exp_q_s[$];

   always #5 clk = ~clk;

   // CUT stand-in: mode 0 = zero-extended vector, 1 = all zero, 2 = all ones
   always_comb begin
      case (mode)
         2'd0:    cut_f = {12'b0, cut_x};
         2'd1:    cut_f = '0;
         default: cut_f = '1;
      endcase
   end

   assign cut_f_s = '1;

   comb_cut_sweeper #(
      .NUM_IN(3), .NUM_OUT(15), .SETTLE_CYC(2),
      .MISR_POLY(15'h6000), .MISR_SEED(15'h0000)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .cut_x(cut_x), .cut_f(cut_f), .busy(busy), .done(done),
      .signature(signature), .vec_idx(vec_idx)
   );

   comb_cut_sweeper #(
      .NUM_IN(2), .NUM_OUT(15), .SETTLE_CYC(1),
      .MISR_POLY(15'h6000), .MISR_SEED(15'h0000)
   ) u_small (
      .clk(clk), .rst_n(rst_n), .start(start_s), .abort(1'b0),
      .cut_x(cut_x_s), .cut_f(cut_f_s), .busy(busy_s), .done(done_s),
      .signature(signature_s), .vec_idx(vec_idx_s)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Bit-level MISR reference for a constant CUT response
   function automatic logic [14:0] misr_ref(input int nvec, input logic [14:0] f);
      logic [14:0] s;
      s = '0;
      for (int v = 0; v < nvec; v++) begin
         s = {s[13:0], 1'b0} ^ (s[14] ? 15'h6000 : 15'h0000) ^ f;
      end
      return s;
   endfunction

   // Scoreboard: every done pulse pops one expected signature
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (exp_q.size() == 0) check("done_unexpected", {31'b0, done}, 32'd0);
         else                   check("signature", {17'b0, signature}, {17'b0, exp_q.pop_front()});
      end
      if (rst_n && done_s) begin
         if (exp_q_s.size() == 0) check("done_s_unexpected", {31'b0, done_s}, 32'd0);
         else                     check("signature_s", {17'b0, signature_s}, {17'b0, exp_q_s.pop_front()});
      end
   end

   // Observe n cycles after a start edge; optional start pulses, held start, abort, and vector-step checks
   task automatic watch(input int n, input int pa, input int pb, input int ab,
                        input bit hold, input bit chk_x,
                        output int fd, output int nd, output int nb, output int ld);
      fd = -1; nd = 0; nb = 0; ld = -1;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         if (done) begin
            nd++;
            if (fd < 0) fd = k;
            ld = k;
         end
         if (busy) nb++;
         if (chk_x && k <= 24) begin
            check("x_step", {29'b0, cut_x}, (k - 1) / 3);
            check("vec_idx_step", {29'b0, vec_idx}, (k - 1) / 3);
         end
         start = hold || (k == pa) || (k == pb);
         abort = (k == ab);
      end
   endtask

   initial begin
      int fd, nd, nb, ld;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0; start_s = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // idle after reset
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("reset_idle", {9'b0, cut_x, vec_idx, busy, done, signature}, 32'd0);
      end

      // default sweep, cut_f = zero-extended cut_x
      @(negedge clk); start = 1'b1; exp_q.push_back(15'h000F);
      watch(30, -1, -1, -1, 1'b0, 1'b1, fd, nd, nb, ld);
      check("a_busy_cycles", nb, 24);
      check("a_done_count", nd, 1);
      check("a_done_edge", fd, 25);
      check("a_x_hold", {29'b0, cut_x}, 32'd7);

      // cut_f tied low
      mode = 2'd1;
      @(negedge clk); start = 1'b1; exp_q.push_back(15'h0000);
      watch(30, -1, -1, -1, 1'b0, 1'b1, fd, nd, nb, ld);
      check("z_done_count", nd, 1);

      // abort during vector 4 settle, right after vector 3 capture
      @(negedge clk); start = 1'b1;
      watch(13, -1, -1, 13, 1'b0, 1'b0, fd, nd, nb, ld);
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_x", {26'b0, cut_x, vec_idx}, 32'd0);
      watch(30, -1, -1, -1, 1'b0, 1'b0, fd, nd, nb, ld);
      check("abort_no_done", nd, 0);

      // start held high: second sweep starts on the edge after DONE
      mode = 2'd0;
      @(negedge clk); start = 1'b1; exp_q.push_back(15'h000F); exp_q.push_back(15'h000F);
      watch(51, -1, -1, -1, 1'b1, 1'b0, fd, nd, nb, ld);
      start = 1'b0;
      check("hold_first_done", fd, 25);
      check("hold_second_done", ld, 51);
      check("hold_done_count", nd, 2);
      check("hold_busy_cycles", nb, 48);
      watch(30, -1, -1, -1, 1'b0, 1'b0, fd, nd, nb, ld);
      check("hold_no_third", nd, 0);

      // start pulses while busy and during DONE are ignored
      @(negedge clk); start = 1'b1; exp_q.push_back(15'h000F);
      watch(30, 5, 25, -1, 1'b0, 1'b0, fd, nd, nb, ld);
      check("pulse_done_count", nd, 1);
      check("pulse_done_edge", fd, 25);
      check("pulse_busy_cycles", nb, 24);

      // asynchronous reset during vector 5 settle
      @(negedge clk); start = 1'b1; exp_q.push_back(15'h000F);
      watch(16, -1, -1, -1, 1'b0, 1'b1, fd, nd, nb, ld);
      #2 rst_n = 1'b0;
      exp_q.delete();
      #1 check("async_reset", {9'b0, cut_x, vec_idx, busy, done, signature}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); start = 1'b1; exp_q.push_back(15'h000F);
      watch(30, -1, -1, -1, 1'b0, 1'b1, fd, nd, nb, ld);
      check("post_reset_done_count", nd, 1);
      check("post_reset_done_edge", fd, 25);

      // small instance: NUM_IN=2, SETTLE_CYC=1, cut_f all ones
      @(negedge clk); start_s = 1'b1; exp_q_s.push_back(misr_ref(4, 15'h7FFF));
      fd = -1; nd = 0; nb = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         start_s = 1'b0;
         if (done_s) begin
            nd++;
            if (fd < 0) fd = k;
         end
         if (busy_s) nb++;
      end
      check("s_done_edge", fd, 9);
      check("s_done_count", nd, 1);
      check("s_busy_cycles", nb, 8);
      check("s_x_final", {28'b0, cut_x_s, vec_idx_s}, 32'hF);

      check("queues_drained", exp_q.size() + exp_q_s.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
